// File: rtl/i2s_rx_if.sv
// I2S receive bus: serial inputs from the external master plus the
// deserialized stereo sample outputs toward the core audio logic.
interface i2s_rx_if #(
  parameter int WIDTH = 16
);
  logic             i2s_bclk;
  logic             i2s_lrclk;
  logic             i2s_din;
  logic [WIDTH-1:0] audio_l;
  logic [WIDTH-1:0] audio_r;
  logic             sample_valid;

  // Side that drives the serial stream and consumes the samples
  modport master (
    output i2s_bclk, i2s_lrclk, i2s_din,
    input  audio_l, audio_r, sample_valid
  );

  // Receiver side
  modport slave (
    input  i2s_bclk, i2s_lrclk, i2s_din,
    output audio_l, audio_r, sample_valid
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronizes BCLK/LRCLK/DATA into the clk domain,
// deserializes each slot MSB first with the standard one-bit delay, and
// reports a left/right pair with a single-cycle strobe.
module i2s_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic     clk,
  input logic     reset,
  i2s_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [SYNC_STAGES-1:0] bclkSync_q;
  logic [SYNC_STAGES-1:0] lrSync_q;
  logic [SYNC_STAGES-1:0] dinSync_q;
  logic                   bclkPrev_q;

  logic             bclkS;
  logic             lrS;
  logic             dinS;
  logic             bclkEdge;

  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [CW-1:0]    bitcnt_q,  bitcnt_d;
  logic             lrPrev_q,  lrPrev_d;
  logic             locked_q,  locked_d;
  logic             haveL_q,   haveL_d;
  logic [WIDTH-1:0] pendL_q,   pendL_d;
  logic [WIDTH-1:0] audioL_q,  audioL_d;
  logic [WIDTH-1:0] audioR_q,  audioR_d;
  logic             valid_q,   valid_d;

  logic [WIDTH-1:0] capShreg;
  logic [CW-1:0]    capCnt;
  logic [WIDTH-1:0] word;

  // Metastability chains on the three asynchronous inputs plus the bclk history flop
  always_ff @(posedge clk) begin
    if (reset) begin
      bclkSync_q <= '0;
      lrSync_q   <= '0;
      dinSync_q  <= '0;
      bclkPrev_q <= 1'b0;
    end else begin
      bclkSync_q <= {bclkSync_q[SYNC_STAGES-2:0], bus.i2s_bclk};
      lrSync_q   <= {lrSync_q[SYNC_STAGES-2:0],   bus.i2s_lrclk};
      dinSync_q  <= {dinSync_q[SYNC_STAGES-2:0],  bus.i2s_din};
      bclkPrev_q <= bclkSync_q[SYNC_STAGES-1];
    end
  end

  assign bclkS    = bclkSync_q[SYNC_STAGES-1];
  assign lrS      = lrSync_q[SYNC_STAGES-1];
  assign dinS     = dinSync_q[SYNC_STAGES-1];
  assign bclkEdge = bclkS & ~bclkPrev_q;

  // Capture a bit on each bclk rising edge and commit the slot when lrclk toggles
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    lrPrev_d = lrPrev_q;
    locked_d = locked_q;
    haveL_d  = haveL_q;
    pendL_d  = pendL_q;
    audioL_d = audioL_q;
    audioR_d = audioR_q;
    valid_d  = 1'b0;
    capShreg = shreg_q;
    capCnt   = bitcnt_q;
    word     = '0;
    if (bclkEdge) begin
      lrPrev_d = lrS;
      // The bit on a transition edge is the LSB of the slot that is ending
      if (bitcnt_q < CW'(WIDTH)) begin
        capShreg = {shreg_q[WIDTH-2:0], dinS};
        capCnt   = bitcnt_q + CW'(1);
      end
      shreg_d  = capShreg;
      bitcnt_d = capCnt;
      if (lrS != lrPrev_q) begin
        // Short slots are left-justified; bits past WIDTH were never shifted in
        word     = capShreg << (CW'(WIDTH) - capCnt);
        shreg_d  = '0;
        bitcnt_d = '0;
        if (!locked_q) begin
          locked_d = 1'b1;
        end else if (!lrPrev_q) begin
          pendL_d = word;
          haveL_d = 1'b1;
        end else if (haveL_q) begin
          audioL_d = pendL_q;
          audioR_d = word;
          valid_d  = 1'b1;
          haveL_d  = 1'b0;
        end
      end
    end
  end

  // Deserializer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      lrPrev_q <= 1'b0;
      locked_q <= 1'b0;
      haveL_q  <= 1'b0;
      pendL_q  <= '0;
      audioL_q <= '0;
      audioR_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      lrPrev_q <= lrPrev_d;
      locked_q <= locked_d;
      haveL_q  <= haveL_d;
      pendL_q  <= pendL_d;
      audioL_q <= audioL_d;
      audioR_q <= audioR_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.audio_l      = audioL_q;
  assign bus.audio_r      = audioR_q;
  assign bus.sample_valid = valid_q;
endmodule
